// File: rtl/uart_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_if : serial line and received-byte handshake for uart_rx   |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
interface uart_rx_if;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rxd, rx_ack,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    input  rxd, rx_ack,
    output rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx : 8N1 oversampling UART receiver with valid/ack byte hold  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  wire logic  clk,
  input  wire logic  rst,
  uart_rx_if.slave   bus
);

  localparam logic [15:0] c_N_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_H_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2;
  logic [15:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        w_load, w_ferr;
  logic [7:0]  r_data;
  logic        r_valid, r_ferr, r_ovr, r_busy;
  logic        w_rx_s;

  assign w_rx_s = r_sync2;

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt + 16'd1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_load        = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_clk_cnt == c_H_LAST) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == c_N_LAST) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == c_N_LAST) begin
          w_clk_cnt_nxt = '0;
          if (w_rx_s) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold here on a stuck-low line so it cannot look like a new start bit
        w_clk_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1   <= bus.rxd;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_load & r_valid & ~bus.rx_ack;
      r_busy <= (w_state_nxt != S_IDLE);
      // A load on the same edge as an ack keeps the byte valid
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (bus.rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire
